multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the 32-bit core datapath: register file, ALU, the 15-bit immediate sign/zero extender, and a shared unified memory port. Each instruction is walked through FETCH/DECODE/EXEC/MEM/WB states. The block emits per-state datapath strobes and mux selects, waits on the memory handshake, and maintains a retired-instruction counter. It sits between the instruction register and every datapath write enable.

---
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle control sequencer for the 32-bit core datapath.
//               Walks every instruction through FETCH/DECODE/EXEC/MEM/WB,
//               emits per-state datapath strobes and mux selects, waits on
//               the unified memory handshake and counts retired instructions.
//               HALT and TRAP are absorbing; only rst leaves them.
// Ports       : clk, rst (async, active-high)
//               opcode[4:0]  IR[31:27], latched in DECODE
//               zero         ALU zero flag, used in the EXEC cycle of BEQ
//               mem_ready    memory completes the current request
//               ir_write, pc_write, pc_branch      PC / IR strobes
//               mem_req, mem_we, mem_addr_sel      memory request
//               ext_sel, alu_src_b, alu_op[1:0]    ALU / extender control
//               reg_write, mem_to_reg              register writeback
//               halted, illegal                    stop status
//               instret[CNT_W-1:0]                 retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ext_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= 5'b00000;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    retire       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_branch    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ext_sel      = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_HALT:              state_d = S_HALT;
          default:              state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (opcode_q)
          // R-type opcodes carry the ALU operation in their low two bits
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_op  = opcode_q[1:0];
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_op    = 2'b00;
            alu_src_b = 1'b1;
            ext_sel   = 1'b1;
            state_d   = S_WB;
          end
          OP_ANDI: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_ORI: begin
            alu_op    = 2'b11;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op    = 2'b00;
            alu_src_b = 1'b1;
            ext_sel   = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op    = 2'b01;
            ext_sel   = 1'b1;
            pc_branch = zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          // Only legal opcodes reach EXEC; anything else is a corrupted register
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode_q == OP_SW);
        if (mem_ready) begin
          if (opcode_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OP_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: halted  = 1'b1;
      S_TRAP: illegal = 1'b1;

      default: state_d = S_FETCH;
    endcase

    instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
  end

  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into its expected per-cycle control vectors from the
//               opcode table, stall counts and zero flag, then compared with
//               the DUT cycle by cycle together with the retire count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  // Packed control vector layout used for expectations
  localparam int B_IRW  = 13;
  localparam int B_PCW  = 12;
  localparam int B_BR   = 11;
  localparam int B_REQ  = 10;
  localparam int B_WE   = 9;
  localparam int B_ASEL = 8;
  localparam int B_EXT  = 7;
  localparam int B_SRCB = 6;
  localparam int B_ALU  = 4;
  localparam int B_RW   = 3;
  localparam int B_M2R  = 2;
  localparam int B_HALT = 1;
  localparam int B_ILL  = 0;

  logic             clk;
  logic             rst;
  logic [4:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             ir_write, pc_write, pc_branch, mem_req, mem_we, mem_addr_sel;
  logic             ext_sel, alu_src_b, reg_write, mem_to_reg, halted, illegal;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  logic [4:0] legal_ops [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                 5'b01000, 5'b01001, 5'b01010,
                                 5'b10000, 5'b10001, 5'b11000};

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ext_sel(ext_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] observed();
    return {ir_write, pc_write, pc_branch, mem_req, mem_we, mem_addr_sel,
            ext_sel, alu_src_b, alu_op, reg_write, mem_to_reg, halted, illegal};
  endfunction

  function automatic logic [13:0] bit1(input int pos);
    logic [13:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  // EXEC-cycle controls straight from the instruction table
  function automatic logic [13:0] exec_vec(input logic [4:0] op, input logic z);
    logic [1:0] aop;
    logic       srcb, ext, br;
    aop = 2'b00; srcb = 1'b0; ext = 1'b0; br = 1'b0;
    case (op)
      5'b00000: aop = 2'b00;
      5'b00001: aop = 2'b01;
      5'b00010: aop = 2'b10;
      5'b00011: aop = 2'b11;
      5'b01000: begin aop = 2'b00; srcb = 1'b1; ext = 1'b1; end
      5'b01001: begin aop = 2'b10; srcb = 1'b1; end
      5'b01010: begin aop = 2'b11; srcb = 1'b1; end
      5'b10000, 5'b10001: begin srcb = 1'b1; ext = 1'b1; end
      5'b11000: begin aop = 2'b01; ext = 1'b1; br = z; end
      default: ;
    endcase
    return (br ? bit1(B_BR) : 14'd0) | (ext ? bit1(B_EXT) : 14'd0) |
           (srcb ? bit1(B_SRCB) : 14'd0) | {8'd0, aop, 4'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare 1 ns later
  task automatic step(input logic rdy, input logic [4:0] op, input logic z,
                      input logic [13:0] exp, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    #1;
    chk($sformatf("%s ctrl", tag), {18'd0, observed()}, {18'd0, exp});
    chk($sformatf("%s instret", tag), instret, model_cnt);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs FETCH and DECODE; for legal opcodes continues to completion
  task automatic run_instr(input logic [4:0] op, input int sf, input int sm,
                           input logic z, input string tag);
    bit is_lw, is_sw, is_beq, is_legal;
    is_lw = (op == 5'b10000);
    is_sw = (op == 5'b10001);
    is_beq = (op == 5'b11000);
    is_legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) is_legal = 1'b1;

    for (int i = 0; i < sf; i++)
      step(1'b0, 5'($urandom), rb(), bit1(B_REQ), {tag, " fetch-wait"});
    step(1'b1, 5'($urandom), rb(), bit1(B_REQ) | bit1(B_IRW) | bit1(B_PCW), {tag, " fetch"});
    step(rb(), op, rb(), 14'd0, {tag, " decode"});
    if (!is_legal) return;

    step(rb(), op, z, exec_vec(op, z), {tag, " exec"});
    if (is_lw || is_sw) begin
      for (int i = 0; i < sm; i++)
        step(1'b0, op, rb(), bit1(B_REQ) | bit1(B_ASEL) | (is_sw ? bit1(B_WE) : 14'd0),
             {tag, " mem-wait"});
      step(1'b1, op, rb(), bit1(B_REQ) | bit1(B_ASEL) | (is_sw ? bit1(B_WE) : 14'd0),
           {tag, " mem"});
    end
    if (!is_sw && !is_beq)
      step(rb(), op, rb(), bit1(B_RW) | (is_lw ? bit1(B_M2R) : 14'd0), {tag, " wb"});
    model_cnt++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    model_cnt = 0;
    chk({tag, " ctrl"}, {18'd0, observed()}, {18'd0, bit1(B_REQ)});
    chk({tag, " instret"}, instret, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] op;
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 5'd0;
    zero = 1'b0;

    #1;
    chk("reset ctrl", {18'd0, observed()}, {18'd0, bit1(B_REQ)});
    chk("reset instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence
    run_instr(5'b00000, 0, 0, 1'b0, "ADD");
    run_instr(5'b01000, 0, 0, 1'b0, "ADDI");
    run_instr(5'b01010, 0, 0, 1'b0, "ORI");
    run_instr(5'b10000, 3, 2, 1'b0, "LW");
    run_instr(5'b10001, 0, 0, 1'b0, "SW");
    run_instr(5'b11000, 0, 0, 1'b1, "BEQ z1");
    run_instr(5'b11000, 0, 0, 1'b0, "BEQ z0");
    run_instr(5'b00001, 1, 0, 1'b1, "SUB");
    run_instr(5'b00010, 0, 0, 1'b0, "AND");
    run_instr(5'b00011, 0, 0, 1'b0, "OR");
    run_instr(5'b01001, 0, 0, 1'b0, "ANDI");

    // Randomized legal instruction stream
    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                $sformatf("rand%0d op%b", n, op));
    end

    // Reset in the middle of a stalled LW memory access
    run_instr(5'b00000, 0, 0, 1'b0, "pre-rst ADD");
    step(1'b1, 5'd0, 1'b0, bit1(B_REQ) | bit1(B_IRW) | bit1(B_PCW), "rstmem fetch");
    step(1'b0, 5'b10000, 1'b0, 14'd0, "rstmem decode");
    step(1'b0, 5'b10000, 1'b0, exec_vec(5'b10000, 1'b0), "rstmem exec");
    step(1'b0, 5'b10000, 1'b0, bit1(B_REQ) | bit1(B_ASEL), "rstmem mem-wait");
    #1;
    rst = 1'b1;
    #1;
    model_cnt = 0;
    chk("rst-in-mem ctrl", {18'd0, observed()}, {18'd0, bit1(B_REQ)});
    chk("rst-in-mem instret", instret, 0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(5'b01000, 0, 0, 1'b0, "post-rst ADDI");

    // Illegal opcode 00111 traps and holds
    run_instr(5'b00111, 0, 0, 1'b0, "ILL");
    for (int i = 0; i < 4; i++)
      step(rb(), 5'($urandom), rb(), bit1(B_ILL), "trap hold");
    do_reset("reset after trap");

    // Random illegal opcodes
    for (int n = 0; n < 4; n++) begin
      bit ok;
      do begin
        op = 5'($urandom);
        ok = (op != 5'b11111);
        foreach (legal_ops[i]) if (legal_ops[i] == op) ok = 1'b0;
      end while (!ok);
      run_instr(5'b00011, 0, 0, 1'b0, "pre-ill OR");
      run_instr(op, $urandom_range(0, 2), 0, 1'b0, $sformatf("ill op%b", op));
      for (int i = 0; i < 3; i++)
        step(rb(), 5'($urandom), rb(), bit1(B_ILL), "trap hold rand");
      do_reset("reset after rand trap");
    end

    // HALT is absorbing and does not retire
    run_instr(5'b10001, 1, 1, 1'b0, "pre-halt SW");
    run_instr(5'b11111, 0, 0, 1'b0, "HALT");
    for (int i = 0; i < 4; i++)
      step(rb(), 5'($urandom), rb(), bit1(B_HALT), "halt hold");
    do_reset("reset after halt");
    run_instr(5'b11000, 0, 0, 1'b1, "post-halt BEQ");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
